// File: rtl/rv_pkg.sv
// RV32I opcode constants and instruction-format classification shared by the
// decode slice.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  function automatic fmt_e fmt_of(input logic [6:0] opcode);
    case (opcode)
      OP_R:                      return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR:  return FMT_I;
      OP_STORE:                  return FMT_S;
      OP_BRANCH:                 return FMT_B;
      OP_LUI, OP_AUIPC:          return FMT_U;
      OP_JAL:                    return FMT_J;
      default:                   return FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-rename bundle for the two-wide decode stage: fetch-side inputs and
// the registered decoded fields handed to rename.
interface decode_stage_if #(parameter int XLEN = 32);
  logic [31:0]     c_di;
  logic            en_flag_di;
  logic [31:0]     instr_1;
  logic [31:0]     instr_2;

  logic [6:0]      opcode_do_1, opcode_do_2;
  logic [2:0]      func3_do_1,  func3_do_2;
  logic [6:0]      func7_do_1,  func7_do_2;
  logic [4:0]      rs1_do_1,    rs1_do_2;
  logic [4:0]      rs2_do_1,    rs2_do_2;
  logic [4:0]      rd_do_1,     rd_do_2;
  logic [XLEN-1:0] imm_do_1,    imm_do_2;
  logic            valid_do_1,  valid_do_2;
  logic [31:0]     instr_do_1,  instr_do_2;
  logic            en_flag_do;
  logic [31:0]     c_do;

  modport master (
    output c_di, en_flag_di, instr_1, instr_2,
    input  opcode_do_1, opcode_do_2, func3_do_1, func3_do_2,
           func7_do_1, func7_do_2, rs1_do_1, rs1_do_2, rs2_do_1, rs2_do_2,
           rd_do_1, rd_do_2, imm_do_1, imm_do_2, valid_do_1, valid_do_2,
           instr_do_1, instr_do_2, en_flag_do, c_do
  );

  modport slave (
    input  c_di, en_flag_di, instr_1, instr_2,
    output opcode_do_1, opcode_do_2, func3_do_1, func3_do_2,
           func7_do_1, func7_do_2, rs1_do_1, rs1_do_2, rs2_do_1, rs2_do_2,
           rd_do_1, rd_do_2, imm_do_1, imm_do_2, valid_do_1, valid_do_2,
           instr_do_1, instr_do_2, en_flag_do, c_do
  );
endinterface

// File: rtl/decode_stage_slot.sv
// Combinational decode of one RV32I instruction word into register fields,
// sign-extended immediate and a format-legality flag.
module decode_slot
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [2:0]      func3,
  output logic [6:0]      func7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic            valid
);

  fmt_e fmt;

  assign opcode = instr[6:0];
  assign func3  = instr[14:12];
  assign func7  = instr[31:25];

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    fmt   = (instr == 32'd0) ? FMT_BAD : fmt_of(instr[6:0]);
    rs1   = instr[19:15];
    rs2   = instr[24:20];
    rd    = instr[11:7];
    imm   = '0;
    valid = 1'b1;
    case (fmt)
      FMT_R: ;
      FMT_I: begin
        rs2 = '0;
        imm = XLEN'($signed(instr[31:20]));
      end
      FMT_S: begin
        rd  = '0;
        imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      end
      FMT_B: begin
        rd  = '0;
        imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      FMT_U: begin
        rs1 = '0;
        rs2 = '0;
        imm = XLEN'($signed({instr[31:12], 12'b0}));
      end
      FMT_J: begin
        rs1 = '0;
        rs2 = '0;
        imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      default: begin
        rs1   = '0;
        rs2   = '0;
        rd    = '0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Two-wide RV32I decode stage: two independent slot decoders followed by a
// single register stage into rename.
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);

  logic [6:0]      opcode_1, opcode_2, func7_1, func7_2;
  logic [2:0]      func3_1, func3_2;
  logic [4:0]      rs1_1, rs1_2, rs2_1, rs2_2, rd_1, rd_2;
  logic [XLEN-1:0] imm_1, imm_2;
  logic            valid_1, valid_2;

  decode_slot #(.XLEN(XLEN)) u_slot_1 (
    .instr(bus.instr_1), .opcode(opcode_1), .func3(func3_1), .func7(func7_1),
    .rs1(rs1_1), .rs2(rs2_1), .rd(rd_1), .imm(imm_1), .valid(valid_1)
  );

  decode_slot #(.XLEN(XLEN)) u_slot_2 (
    .instr(bus.instr_2), .opcode(opcode_2), .func3(func3_2), .func7(func7_2),
    .rs1(rs1_2), .rs2(rs2_2), .rd(rd_2), .imm(imm_2), .valid(valid_2)
  );

  // NOTE: state is written with <= so both slots and the tag sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.c_do        <= '0;
      bus.en_flag_do  <= 1'b0;
      bus.valid_do_1  <= 1'b0;
      bus.valid_do_2  <= 1'b0;
      bus.opcode_do_1 <= '0;
      bus.opcode_do_2 <= '0;
      bus.func3_do_1  <= '0;
      bus.func3_do_2  <= '0;
      bus.func7_do_1  <= '0;
      bus.func7_do_2  <= '0;
      bus.rs1_do_1    <= '0;
      bus.rs1_do_2    <= '0;
      bus.rs2_do_1    <= '0;
      bus.rs2_do_2    <= '0;
      bus.rd_do_1     <= '0;
      bus.rd_do_2     <= '0;
      bus.imm_do_1    <= '0;
      bus.imm_do_2    <= '0;
      bus.instr_do_1  <= '0;
      bus.instr_do_2  <= '0;
    end else begin
      bus.c_do       <= bus.c_di;
      bus.en_flag_do <= bus.en_flag_di;
      bus.valid_do_1 <= bus.en_flag_di & valid_1;
      bus.valid_do_2 <= bus.en_flag_di & valid_2;
      // A disabled bundle only drops the valids; decoded fields keep their last values.
      if (bus.en_flag_di) begin
        bus.opcode_do_1 <= opcode_1;
        bus.opcode_do_2 <= opcode_2;
        bus.func3_do_1  <= func3_1;
        bus.func3_do_2  <= func3_2;
        bus.func7_do_1  <= func7_1;
        bus.func7_do_2  <= func7_2;
        bus.rs1_do_1    <= rs1_1;
        bus.rs1_do_2    <= rs1_2;
        bus.rs2_do_1    <= rs2_1;
        bus.rs2_do_2    <= rs2_2;
        bus.rd_do_1     <= rd_1;
        bus.rd_do_2     <= rd_2;
        bus.imm_do_1    <= imm_1;
        bus.imm_do_2    <= imm_2;
        bus.instr_do_1  <= bus.instr_1;
        bus.instr_do_2  <= bus.instr_2;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, hand-written
// enable/reset sequences and randomized bundles against a reference model.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) bus ();

  decode_stage #(.XLEN(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        valid;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        valid;
  } vec_t;

  exp_t        m [2];
  logic [31:0] m_c;
  logic        m_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference decode computed from field positions with plain shifts and masks.
  function automatic exp_t ref_decode(input logic [31:0] i);
    exp_t e;
    logic use_rs1, use_rs2, use_rd, known;
    logic signed [31:0] hi;
    e.instr  = i;
    e.opcode = i[6:0];
    e.func3  = i[14:12];
    e.func7  = i[31:25];
    e.imm    = 32'd0;
    known    = 1'b1;
    {use_rs1, use_rs2, use_rd} = 3'b000;
    case (i[6:0])
      7'h33: {use_rs1, use_rs2, use_rd} = 3'b111;
      7'h13, 7'h03, 7'h67: begin
        {use_rs1, use_rs2, use_rd} = 3'b101;
        hi = $signed(i) >>> 20;
        e.imm = hi;
      end
      7'h23: begin
        {use_rs1, use_rs2, use_rd} = 3'b110;
        hi = $signed(i) >>> 25;
        e.imm = (hi << 5) | ((i >> 7) & 32'h1F);
      end
      7'h63: begin
        {use_rs1, use_rs2, use_rd} = 3'b110;
        hi = $signed(i) >>> 31;
        e.imm = (hi << 12) | (((i >> 7) & 32'h1) << 11) | (((i >> 25) & 32'h3F) << 5)
              | (((i >> 8) & 32'hF) << 1);
      end
      7'h37, 7'h17: begin
        use_rd = 1'b1;
        e.imm  = i & 32'hFFFFF000;
      end
      7'h6F: begin
        use_rd = 1'b1;
        hi = $signed(i) >>> 31;
        e.imm = (hi << 20) | (i & 32'h000FF000) | (((i >> 20) & 32'h1) << 11)
              | (((i >> 21) & 32'h3FF) << 1);
      end
      default: known = 1'b0;
    endcase
    e.valid = known && (i != 32'd0);
    if (!e.valid) e.imm = 32'd0;
    e.rs1 = (e.valid && use_rs1) ? 5'((i >> 15) & 32'h1F) : 5'd0;
    e.rs2 = (e.valid && use_rs2) ? 5'((i >> 20) & 32'h1F) : 5'd0;
    e.rd  = (e.valid && use_rd)  ? 5'((i >> 7)  & 32'h1F) : 5'd0;
    return e;
  endfunction

  task automatic check_slot(input string tag, input exp_t e,
                            input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                            input logic [31:0] imm, input logic v, input logic [31:0] ins);
    check({tag, ".opcode"}, 32'(op),  32'(e.opcode));
    check({tag, ".func3"},  32'(f3),  32'(e.func3));
    check({tag, ".func7"},  32'(f7),  32'(e.func7));
    check({tag, ".rs1"},    32'(r1),  32'(e.rs1));
    check({tag, ".rs2"},    32'(r2),  32'(e.rs2));
    check({tag, ".rd"},     32'(rd),  32'(e.rd));
    check({tag, ".imm"},    imm,      e.imm);
    check({tag, ".valid"},  32'(v),   32'(e.valid));
    check({tag, ".instr"},  ins,      e.instr);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".c_do"},    bus.c_do,              m_c);
    check({tag, ".en_flag"}, 32'(bus.en_flag_do),   32'(m_en));
    check_slot({tag, ".s1"}, m[0], bus.opcode_do_1, bus.func3_do_1, bus.func7_do_1,
               bus.rs1_do_1, bus.rs2_do_1, bus.rd_do_1, bus.imm_do_1, bus.valid_do_1,
               bus.instr_do_1);
    check_slot({tag, ".s2"}, m[1], bus.opcode_do_2, bus.func3_do_2, bus.func7_do_2,
               bus.rs1_do_2, bus.rs2_do_2, bus.rd_do_2, bus.imm_do_2, bus.valid_do_2,
               bus.instr_do_2);
  endtask

  // Apply one bundle, advance one edge, update the model, compare everything.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic [31:0] c, input logic [31:0] i1, input logic [31:0] i2);
    rst            = r;
    bus.en_flag_di = e;
    bus.c_di       = c;
    bus.instr_1    = i1;
    bus.instr_2    = i2;
    @(posedge clk);
    if (r) begin
      m_c  = 32'd0;
      m_en = 1'b0;
      for (int k = 0; k < 2; k++) m[k] = '{default: '0};
    end else begin
      m_c  = c;
      m_en = e;
      if (e) begin
        m[0] = ref_decode(i1);
        m[1] = ref_decode(i2);
      end else begin
        m[0].valid = 1'b0;
        m[1].valid = 1'b0;
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  localparam int NV = 8;
  vec_t vecs [NV];
  logic [6:0] ops [10];

  initial begin
    vecs[0] = '{32'h002081B3, 5'd1, 5'd2, 5'd3, 32'h00000000, 1'b1};
    vecs[1] = '{32'hFFF08093, 5'd1, 5'd0, 5'd1, 32'hFFFFFFFF, 1'b1};
    vecs[2] = '{32'h00112423, 5'd2, 5'd1, 5'd0, 32'h00000008, 1'b1};
    vecs[3] = '{32'hFE000EE3, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b1};
    vecs[4] = '{32'h123452B7, 5'd0, 5'd0, 5'd5, 32'h12345000, 1'b1};
    vecs[5] = '{32'h008000EF, 5'd0, 5'd0, 5'd1, 32'h00000008, 1'b1};
    vecs[6] = '{32'h00000000, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0};
    vecs[7] = '{32'h0000007F, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0};
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};

    rst = 1'b1;
    bus.en_flag_di = 1'b0;
    bus.c_di = 32'd0;
    bus.instr_1 = 32'd0;
    bus.instr_2 = 32'd0;

    // Reset held two cycles, then the first bundle shows up one cycle after release.
    step("reset0", 1'b1, 1'b1, 32'd3, 32'h002081B3, 32'hFFF08093);
    step("reset1", 1'b1, 1'b1, 32'd4, 32'h002081B3, 32'hFFF08093);
    check("reset.valid_do_1", 32'(bus.valid_do_1), 32'd0);
    check("reset.imm_do_2",   bus.imm_do_2,         32'd0);
    step("release", 1'b0, 1'b1, 32'd5, 32'h002081B3, 32'hFFF08093);
    check("release.c_do", bus.c_do, 32'd5);

    // Directed table: slot 1 takes vector i, slot 2 takes vector i+1.
    for (int i = 0; i < NV; i++) begin
      int j;
      j = (i + 1) % NV;
      step("table", 1'b0, 1'b1, 32'(100 + i), vecs[i].instr, vecs[j].instr);
      check("tbl.s1.rs1",   32'(bus.rs1_do_1),   32'(vecs[i].rs1));
      check("tbl.s1.rs2",   32'(bus.rs2_do_1),   32'(vecs[i].rs2));
      check("tbl.s1.rd",    32'(bus.rd_do_1),    32'(vecs[i].rd));
      check("tbl.s1.imm",   bus.imm_do_1,        vecs[i].imm);
      check("tbl.s1.valid", 32'(bus.valid_do_1), 32'(vecs[i].valid));
      check("tbl.s2.rd",    32'(bus.rd_do_2),    32'(vecs[j].rd));
      check("tbl.s2.imm",   bus.imm_do_2,        vecs[j].imm);
      check("tbl.s2.valid", 32'(bus.valid_do_2), 32'(vecs[j].valid));
    end

    // Disabled bundle: valids drop, decoded fields hold, tag still tracks.
    step("pre_hold", 1'b0, 1'b1, 32'd7, 32'h123452B7, 32'h008000EF);
    step("hold", 1'b0, 1'b0, 32'd8, 32'h002081B3, 32'hFFF08093);
    check("hold.valid_do_1", 32'(bus.valid_do_1), 32'd0);
    check("hold.valid_do_2", 32'(bus.valid_do_2), 32'd0);
    check("hold.rd_do_1",    32'(bus.rd_do_1),    32'd5);
    check("hold.imm_do_2",   bus.imm_do_2,        32'h00000008);
    check("hold.en_flag_do", 32'(bus.en_flag_do), 32'd0);
    check("hold.c_do",       bus.c_do,            32'd8);

    // Same destination in both slots passes through untouched.
    step("same_rd", 1'b0, 1'b1, 32'd9, 32'h002081B3, 32'h00A00193);
    check("same_rd.rd_do_1", 32'(bus.rd_do_1), 32'd3);
    check("same_rd.rd_do_2", 32'(bus.rd_do_2), 32'd3);

    // Reset mid-stream beats an enabled bundle.
    step("mid_reset", 1'b1, 1'b1, 32'd10, 32'h002081B3, 32'h123452B7);
    check("mid_reset.rd_do_2", 32'(bus.rd_do_2), 32'd0);
    check("mid_reset.c_do",    bus.c_do,         32'd0);
    step("post_reset", 1'b0, 1'b1, 32'd11, 32'h123452B7, 32'h002081B3);
    check("post_reset.c_do", bus.c_do, 32'd11);

    // Randomized bundles, occasional disables, bubbles and resets.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] w [2];
      logic r, e;
      for (int k = 0; k < 2; k++) begin
        w[k] = $urandom();
        w[k][6:0] = ops[$urandom_range(9)];
        if ($urandom_range(15) == 0) w[k] = 32'd0;
      end
      e = ($urandom_range(4) != 0);
      r = ($urandom_range(39) == 0);
      step("rand", r, e, $urandom(), w[0], w[1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
